// File: rtl/ifetch_resp_pkg.sv
// Shared types and constants for the instruction-fetch response path.
// Optional misalign tracking is compiled in with IFETCH_MISALIGN_CHECK_EN.
package ifetch_resp_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
`ifdef IFETCH_MISALIGN_CHECK_EN
        logic        misalign;
`endif
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    typedef struct packed {
`ifdef IFETCH_MISALIGN_CHECK_EN
        logic        misalign;
`endif
        logic [31:0] pc;
    } tag_t;

endpackage

// File: rtl/ifetch_resp_sync_fifo.sv
// Synchronous FIFO with push/pop/clear and occupancy count; storage reads
// as zero after reset until first written.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    input  logic                     clear,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        full    = (count == (AW+1)'(DEPTH));
        empty   = (count == '0);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        rdata   = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (AW+1)'(1);
            end else if (!do_push && do_pop) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/ifetch_resp.sv
// Instruction-fetch request/response tracker: tags requests with their PC and
// queues returned words for decode. Macro IFETCH_MISALIGN_CHECK_EN adds dec_misalign.
module ifetch_resp
    import ifetch_resp_pkg::*;
#(
    parameter int unsigned DEPTH  = 2,
    parameter logic [31:0] RST_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    output logic        pc_we,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        flush,
    output logic        dec_valid,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    input  logic        dec_ready
`ifdef IFETCH_MISALIGN_CHECK_EN
    ,
    output logic        dec_misalign
`endif
);
    localparam int unsigned CW  = $clog2(DEPTH) + 1;
    // Discarded responses sit outside the credit window, so back-to-back
    // flushes can leave more than DEPTH of them in flight.
    localparam int unsigned DCW = CW + 2;

    tag_t           tag_wdata;
    tag_t           tag_rdata;
    logic           tag_full;
    logic           tag_empty;
    logic [CW-1:0]  tag_count;
    logic           tag_push;
    logic           tag_pop;

    entry_t         q_wdata;
    entry_t         q_rdata;
    logic           q_full;
    logic           q_empty;
    logic [CW-1:0]  q_count;
    logic           q_push;
    logic           q_pop;

    logic [DCW-1:0] discard_cnt;
    logic [DCW-1:0] discard_nxt;
    logic [DCW-1:0] pending;
    logic [CW:0]    credit_sum;
    logic           can_issue;
    logic           fire;
    logic           rsp_live;
    logic           direct_push;
    logic           pc_misalign;

    always_comb begin
        credit_sum = {1'b0, q_count} + {1'b0, tag_count};
        can_issue  = !rst && !flush && !tag_full && !q_full
                     && (credit_sum < (CW+1)'(DEPTH));
`ifdef IFETCH_MISALIGN_CHECK_EN
        pc_misalign    = (pc_in[1:0] != 2'b00);
        imem_req_valid = can_issue && !pc_misalign;
        // Misaligned entries bypass memory, so they wait for older fetches to drain.
        fire           = pc_misalign ? (can_issue && tag_empty)
                                     : (imem_req_valid && imem_req_ready);
`else
        pc_misalign    = 1'b0;
        imem_req_valid = can_issue;
        fire           = imem_req_valid && imem_req_ready;
`endif
        imem_req_addr = pc_in;
        pc_we         = fire;
        tag_push      = fire && !pc_misalign;
        direct_push   = fire && pc_misalign;
        rsp_live      = imem_rsp_valid && (discard_cnt == '0) && !tag_empty;
        tag_pop       = rsp_live;
        q_push        = rsp_live || direct_push;
        q_pop         = dec_valid && dec_ready;
    end

    always_comb begin
        tag_wdata    = '0;
        tag_wdata.pc = pc_in;
        q_wdata       = '0;
        q_wdata.pc    = tag_rdata.pc;
        q_wdata.instr = imem_rsp_data;
`ifdef IFETCH_MISALIGN_CHECK_EN
        tag_wdata.misalign = pc_misalign;
        q_wdata.misalign   = tag_rdata.misalign;
        if (direct_push) begin
            q_wdata.pc       = pc_in;
            q_wdata.instr    = NOP_INSTR;
            q_wdata.misalign = 1'b1;
        end
`endif
    end

    always_comb begin
        discard_nxt = discard_cnt;
        pending     = discard_cnt + DCW'(tag_count);
        if (flush) begin
            discard_nxt = (imem_rsp_valid && pending != '0) ? pending - DCW'(1) : pending;
        end else if (imem_rsp_valid && discard_cnt != '0) begin
            discard_nxt = discard_cnt - DCW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            discard_cnt <= '0;
        end else begin
            discard_cnt <= discard_nxt;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(tag_t)),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tag_push),
        .wdata (tag_wdata),
        .pop   (tag_pop),
        .clear (flush),
        .rdata (tag_rdata),
        .full  (tag_full),
        .empty (tag_empty),
        .count (tag_count)
    );

    sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_instr_q (
        .clk   (clk),
        .rst   (rst),
        .push  (q_push),
        .wdata (q_wdata),
        .pop   (q_pop),
        .clear (flush),
        .rdata (q_rdata),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    always_comb begin
        dec_valid = !q_empty;
        dec_instr = q_rdata.instr;
        dec_pc    = q_rdata.pc;
`ifdef IFETCH_MISALIGN_CHECK_EN
        dec_misalign = q_rdata.misalign;
`endif
    end

endmodule

// File: tb/tb_ifetch_resp.sv
// Self-checking bench for ifetch_resp: directed scenarios plus randomized
// traffic against a queue-based reference model and in-order memory model.
module tb_ifetch_resp;
    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic        pc_we;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        flush;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        dec_ready;
`ifdef IFETCH_MISALIGN_CHECK_EN
    logic        dec_misalign;
`endif

    always #5 clk = ~clk;

    ifetch_resp #(.DEPTH(DEPTH), .RST_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_in          (pc_in),
        .pc_we          (pc_we),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .flush          (flush),
        .dec_valid      (dec_valid),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .dec_ready      (dec_ready)
`ifdef IFETCH_MISALIGN_CHECK_EN
        ,
        .dec_misalign   (dec_misalign)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        mis;
    } ent_t;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } mreq_t;

    ent_t        iq[$];
    logic [31:0] live[$];
    mreq_t       mem_q[$];
    int          disc;
    int unsigned n_vec;
    int unsigned n_err;
    int unsigned cyc;
    int unsigned last_due;
    int unsigned lat_max;
    bit          mem_hold;
    logic [31:0] pc;
    logic [31:0] flush_tgt;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // Entered just after a rising edge; leaves just after the next one.
    task automatic cycle(input logic fl, input logic rdy, input logic drdy);
        logic        rsp, mis, credit, exp_fire;
        logic [31:0] rdata;
        int unsigned lat, due;
        mis = 1'b0;
`ifdef IFETCH_MISALIGN_CHECK_EN
        mis = (pc[1:0] != 2'b00);
`endif
        rsp   = !mem_hold && mem_q.size() > 0 && mem_q[0].due <= cyc;
        rdata = rsp ? mem_data(mem_q[0].addr) : $urandom;
        pc_in = pc; flush = fl; imem_req_ready = rdy; dec_ready = drdy;
        imem_rsp_valid = rsp; imem_rsp_data = rdata;
        #4;
        credit   = !fl && (iq.size() + live.size() < DEPTH);
        exp_fire = mis ? (credit && live.size() == 0) : (credit && rdy);
        check("req_valid", imem_req_valid, credit && !mis);
        check("pc_we", pc_we, exp_fire);
        check("req_addr", imem_req_addr, pc);
        check("dec_valid", dec_valid, iq.size() != 0);
        if (iq.size() != 0) begin
            check("dec_pc", dec_pc, iq[0].pc);
            check("dec_instr", dec_instr, iq[0].instr);
`ifdef IFETCH_MISALIGN_CHECK_EN
            check("dec_misalign", dec_misalign, iq[0].mis);
`endif
        end
        if (rsp) mem_q.delete(0);
        if (fl) begin
            disc = disc + live.size();
            if (rsp && disc > 0) disc--;
            live.delete();
            iq.delete();
            pc = flush_tgt;
        end else begin
            if (drdy && iq.size() != 0) iq.delete(0);
            if (rsp) begin
                if (disc > 0) disc--;
                else begin
                    check("rsp_has_tag", live.size() != 0, 1'b1);
                    if (live.size() != 0) begin
                        iq.push_back('{pc: live[0], instr: rdata, mis: 1'b0});
                        live.delete(0);
                    end
                end
            end
            if (exp_fire) begin
                if (mis) iq.push_back('{pc: pc, instr: NOP, mis: 1'b1});
                else begin
                    live.push_back(pc);
                    lat = $urandom_range(1, lat_max);
                    due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                    last_due = due;
                    mem_q.push_back('{addr: pc, due: due});
                end
                pc = pc + 32'd4;
            end
        end
        cyc++;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        imem_req_ready = 1'b1; dec_ready = 1'b1; pc_in = 32'h0;
        #4;
        check("rst_req_valid", imem_req_valid, 1'b0);
        check("rst_pc_we", pc_we, 1'b0);
        @(posedge clk); #5;
        check("rst_dec_valid", dec_valid, 1'b0);
        check("rst_req_valid2", imem_req_valid, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        iq.delete(); live.delete(); mem_q.delete();
        disc = 0; pc = 32'h0; cyc++; last_due = cyc;
    endtask

    initial begin
        n_vec = 0; n_err = 0; cyc = 0; last_due = 0; lat_max = 1; mem_hold = 0;
        disc = 0; pc = 32'h0; flush_tgt = 32'h0;
        do_reset();
        check("rst_dec_pc", dec_pc, 32'h0);
        check("rst_dec_instr", dec_instr, 32'h0);

        // Streaming with one-cycle memory.
        repeat (8) cycle(1'b0, 1'b1, 1'b1);
        // Decode stalled: credits run out after DEPTH fires.
        repeat (6) cycle(1'b0, 1'b1, 1'b0);
        repeat (4) cycle(1'b0, 1'b1, 1'b1);
        // Memory not ready.
        repeat (5) cycle(1'b0, 1'b0, 1'b1);
        repeat (4) cycle(1'b0, 1'b1, 1'b1);

        // Flush with two outstanding, nothing returning.
        repeat (4) cycle(1'b0, 1'b0, 1'b1);
        mem_hold = 1;
        repeat (3) cycle(1'b0, 1'b1, 1'b1);
        flush_tgt = 32'h100;
        cycle(1'b1, 1'b1, 1'b1);
        mem_hold = 0;
        repeat (8) cycle(1'b0, 1'b1, 1'b1);

        // Flush coinciding with one returning response.
        repeat (4) cycle(1'b0, 1'b0, 1'b1);
        mem_hold = 1;
        repeat (3) cycle(1'b0, 1'b1, 1'b1);
        mem_hold = 0;
        flush_tgt = 32'h300;
        cycle(1'b1, 1'b1, 1'b1);
        repeat (8) cycle(1'b0, 1'b1, 1'b1);

`ifdef IFETCH_MISALIGN_CHECK_EN
        repeat (6) cycle(1'b0, 1'b0, 1'b1);
        pc = 32'h6;
        cycle(1'b0, 1'b0, 1'b0);
        pc = 32'h200;
        repeat (3) cycle(1'b0, 1'b0, 1'b1);
`endif

        // Randomized traffic with a mid-run reset.
        lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1200) do_reset();
            flush_tgt = 32'($urandom_range(0, 4095)) << 2;
            cycle($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
